// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//
// Front end for the digital clock's manual controls. Raw push buttons are
// synchronised, debounced and turned into press strobes. The advance buttons
// also get auto-repeat strobes. A free-running divider produces the
// once-per-period pulse that the clock counters consume.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   raw_btn    [NB] asynchronous raw button levels
//   btn_lvl    [NB] debounced button levels
//   btn_press  [NB] one-cycle strobe on each debounced 0->1 transition
//   btn_rpt    [NB] press strobe plus auto-repeat strobes (bits in RPT_MASK)
//   pulse      one-cycle tick every TICK_DIV cycles
//
// Button bit map: 0 Timeset, 1 Alarmset, 2 Alarmon, 3 Minadv, 4 Hrsadv.
// ---------------------------------------------------------------------------
module btn_conditioner #(
  parameter int              NB         = 5,
  parameter int              DB_CYCLES  = 4,
  parameter int              TICK_DIV   = 10,
  parameter int              RPT_DELAY  = 8,
  parameter int              RPT_PERIOD = 3,
  parameter logic [NB-1:0]   RPT_MASK   = 5'b11000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NB-1:0] raw_btn,
  output logic [NB-1:0] btn_lvl,
  output logic [NB-1:0] btn_press,
  output logic [NB-1:0] btn_rpt,
  output logic          pulse
);

  // Counter widths: $clog2 of the largest count, never narrower than 1 bit.
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RC_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [RC_W-1:0]   DELAY_LAST  = RC_W'(RPT_DELAY - 1);
  localparam logic [RC_W-1:0]   PERIOD_LAST = RC_W'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // -------------------------------------------------------------------------
  // Tick generator
  // -------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt_reg;
  logic [TICK_W-1:0] tick_cnt_next;
  logic              pulse_reg;

  always_comb begin
    tick_cnt_next = (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + TICK_W'(1);
  end

  // pulse is registered from the upcoming count so that it is high in exactly
  // the cycles where tick_cnt_reg reads TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_reg <= '0;
      pulse_reg    <= 1'b0;
    end else begin
      tick_cnt_reg <= tick_cnt_next;
      pulse_reg    <= (tick_cnt_next == TICK_LAST);
    end
  end

  assign pulse = pulse_reg;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser on the raw inputs
  // -------------------------------------------------------------------------
  logic [NB-1:0] sync1_reg;
  logic [NB-1:0] sync2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_btn;
      sync2_reg <= sync1_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Per-button debounce, press detect and auto-repeat
  // -------------------------------------------------------------------------
  logic              lvl_reg   [NB];
  logic              press_reg [NB];
  logic              rpt_reg   [NB];
  logic [DB_W-1:0]   db_cnt_reg [NB];
  logic [RC_W-1:0]   rc_reg    [NB];
  rpt_state_e        state_reg [NB];

  logic [NB-1:0]     db_toggle;
  logic [NB-1:0]     lvl_next;
  logic [NB-1:0]     rise_next;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      // The level flips on the DB_CYCLES-th consecutive differing sample.
      assign db_toggle[gi] = (sync2_reg[gi] != lvl_reg[gi]) && (db_cnt_reg[gi] == DB_LAST);
      assign lvl_next[gi]  = lvl_reg[gi] ^ db_toggle[gi];
      assign rise_next[gi] = db_toggle[gi] & ~lvl_reg[gi];

      // The repeat FSM looks at lvl_next/rise_next so that its registered
      // strobe lands in the same cycle as the new level and press strobe,
      // and a release suppresses a strobe due in that same cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          db_cnt_reg[gi] <= '0;
          lvl_reg[gi]    <= 1'b0;
          press_reg[gi]  <= 1'b0;
          rpt_reg[gi]    <= 1'b0;
          rc_reg[gi]     <= '0;
          state_reg[gi]  <= IDLE;
        end else begin
          // Debounce counter
          if (sync2_reg[gi] == lvl_reg[gi]) begin
            db_cnt_reg[gi] <= '0;
          end else if (db_cnt_reg[gi] == DB_LAST) begin
            db_cnt_reg[gi] <= '0;
          end else begin
            db_cnt_reg[gi] <= db_cnt_reg[gi] + DB_W'(1);
          end

          lvl_reg[gi]   <= lvl_next[gi];
          press_reg[gi] <= rise_next[gi];
          rpt_reg[gi]   <= 1'b0;

          case (state_reg[gi])
            IDLE: begin
              if (rise_next[gi]) begin
                rpt_reg[gi]   <= 1'b1;
                rc_reg[gi]    <= '0;
                state_reg[gi] <= HOLD;
              end
            end

            HOLD: begin
              if (!lvl_next[gi]) begin
                state_reg[gi] <= IDLE;
              end else if (RPT_MASK[gi] && (rc_reg[gi] == DELAY_LAST)) begin
                rpt_reg[gi]   <= 1'b1;
                rc_reg[gi]    <= '0;
                state_reg[gi] <= REPEAT;
              end else begin
                // Non-repeating buttons park here until release; the count
                // is never compared for them, so wrapping is harmless.
                rc_reg[gi] <= rc_reg[gi] + RC_W'(1);
              end
            end

            REPEAT: begin
              if (!lvl_next[gi]) begin
                state_reg[gi] <= IDLE;
              end else if (rc_reg[gi] == PERIOD_LAST) begin
                rpt_reg[gi] <= 1'b1;
                rc_reg[gi]  <= '0;
              end else begin
                rc_reg[gi] <= rc_reg[gi] + RC_W'(1);
              end
            end

            default: begin
              state_reg[gi] <= IDLE;
              rc_reg[gi]    <= '0;
            end
          endcase
        end
      end

      assign btn_lvl[gi]   = lvl_reg[gi];
      assign btn_press[gi] = press_reg[gi];
      assign btn_rpt[gi]   = rpt_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
//
// Scoreboard bench for btn_conditioner. A reference model, sampling the same
// inputs the DUT sees at each rising edge, pushes the expected outputs into a
// queue; a monitor on the falling edge pops and compares. The model works from
// sample history: a level change is accepted when the last DB_CYCLES
// synchronised samples all disagree with the current level, and repeat
// strobes are computed from the distance to the most recent press.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int            NB         = 5;
  localparam int            DB_CYCLES  = 4;
  localparam int            TICK_DIV   = 10;
  localparam int            RPT_DELAY  = 8;
  localparam int            RPT_PERIOD = 3;
  localparam logic [NB-1:0] RPT_MASK   = 5'b11000;
  localparam int            MAXC       = 8000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] raw_btn = '0;
  logic [NB-1:0] btn_lvl;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_rpt;
  logic          pulse;

  btn_conditioner #(
    .NB(NB), .DB_CYCLES(DB_CYCLES), .TICK_DIV(TICK_DIV),
    .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD), .RPT_MASK(RPT_MASK)
  ) dut (
    .clk(clk), .rst(rst), .raw_btn(raw_btn),
    .btn_lvl(btn_lvl), .btn_press(btn_press), .btn_rpt(btn_rpt), .pulse(pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NB-1:0] lvl;
    logic [NB-1:0] press;
    logic [NB-1:0] rpt;
    logic          pulse;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   started = 0;

  // ---------------- reference model ----------------
  logic [NB-1:0] raw_h [MAXC];
  bit            rst_h [MAXC];

  // Output of a two-flop synchroniser in effect at edge k: the raw value
  // sampled two edges earlier, or 0 if either flop was cleared since.
  function automatic logic sync_at(int b, int k);
    if (k < 2) return 1'b0;
    if (rst_h[k-1] || rst_h[k-2]) return 1'b0;
    return raw_h[k-2][b];
  endfunction

  initial begin : model
    int            n;
    int            run;
    int            d;
    int            press_at [NB];
    logic [NB-1:0] lvl_m;
    bit            tog;
    exp_t          e;
    n = 0;
    run = 0;
    lvl_m = '0;
    for (int b = 0; b < NB; b++) press_at[b] = -1;
    forever begin
      @(posedge clk);
      if (n >= MAXC) begin
        $display("FAIL model_overflow cyc=%0d limit=%0d", n, MAXC);
        $fatal(1, "history overflow");
      end
      rst_h[n] = rst;
      raw_h[n] = raw_btn;
      e.cyc = n;
      e.lvl = '0; e.press = '0; e.rpt = '0; e.pulse = 1'b0;
      if (rst) begin
        run   = 0;
        lvl_m = '0;
        for (int b = 0; b < NB; b++) press_at[b] = -1;
      end else begin
        run++;
        e.pulse = ((run % TICK_DIV) == TICK_DIV - 1);
        for (int b = 0; b < NB; b++) begin
          tog = (run >= DB_CYCLES);
          for (int j = 0; j < DB_CYCLES; j++)
            if (sync_at(b, n - j) == lvl_m[b]) tog = 0;
          if (tog) begin
            lvl_m[b] = ~lvl_m[b];
            if (lvl_m[b]) begin
              e.press[b]  = 1'b1;
              press_at[b] = n;
            end else begin
              press_at[b] = -1;
            end
          end
          if (lvl_m[b] && press_at[b] >= 0) begin
            d = n - press_at[b];
            if (d == 0)
              e.rpt[b] = 1'b1;
            else if (RPT_MASK[b] && d >= RPT_DELAY && ((d - RPT_DELAY) % RPT_PERIOD) == 0)
              e.rpt[b] = 1'b1;
          end
        end
        e.lvl = lvl_m;
      end
      exp_q.push_back(e);
      started = 1;
      n++;
    end
  end

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [NB-1:0] got,
                     input logic [NB-1:0] exp, input int cyc);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        if (started) begin
          checks++;
          errors++;
          $display("FAIL queue_empty time=%0t got=0 exp=1", $time);
        end
      end else begin
        e = exp_q.pop_front();
        chk("lvl",   btn_lvl,   e.lvl,   e.cyc);
        chk("press", btn_press, e.press, e.cyc);
        chk("rpt",   btn_rpt,   e.rpt,   e.cyc);
        chk("pulse", {{(NB-1){1'b0}}, pulse}, {{(NB-1){1'b0}}, e.pulse}, e.cyc);
        if (e.press != '0 || e.rpt != '0)
          $display("cyc=%0d lvl=%b press=%b rpt=%b", e.cyc, btn_lvl, btn_press, btn_rpt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [NB-1:0] r, input logic rs);
    raw_btn = r;
    rst     = rs;
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic [NB-1:0] r, input int cycles);
    for (int i = 0; i < cycles; i++) step(r, 1'b0);
  endtask

  initial begin : stim
    logic [NB-1:0] r;
    int            dur [NB];

    // Reset, then idle: pulse ticks, no button activity.
    for (int i = 0; i < 3; i++) step('0, 1'b1);
    hold('0, 25);

    // Bit 0 bounces 1,0,1 then holds: one press, no repeats (masked).
    step(5'b00001, 1'b0);
    step(5'b00000, 1'b0);
    hold(5'b00001, 40);
    hold('0, 12);

    // Bit 3 long hold: press plus repeat train, then release.
    hold(5'b01000, 40);
    hold('0, 12);

    // Bit 4 glitch shorter than the debounce window: rejected.
    hold(5'b10000, 3);
    hold('0, 12);

    // Bit 3 held through a one-cycle reset during the repeat phase.
    hold(5'b01000, 15);
    step(5'b01000, 1'b1);
    hold(5'b01000, 30);
    hold('0, 12);

    // Bits 3 and 4 together: coincident repeat trains.
    hold(5'b11000, 30);
    hold('0, 12);

    // Randomised holds and bounces on all bits, with occasional resets.
    r = '0;
    for (int b = 0; b < NB; b++) dur[b] = int'($urandom_range(1, 20));
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (dur[b] == 0) begin
          r[b] = ~r[b];
          if ($urandom_range(0, 2) == 0) dur[b] = int'($urandom_range(1, 4));
          else                           dur[b] = int'($urandom_range(5, 40));
        end else begin
          dur[b]--;
        end
      end
      step(r, ($urandom_range(0, 299) == 0));
    end
    hold('0, 12);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
